combo_scorer: RTL and testbench
===============================

COMBO_SCORER -- requirements
Module: combo_scorer

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 17, meaning display refresh counter width; the top 2 bits select the digit.
REQ-002 SHALL have parameter COMBO_MAX, default 99, meaning the combo saturation value.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port state  input  4  game state (0 GAMESTART, 1 EASY, 2 NORMAL, 3 HARD, 4 INFERNO, 5 FAILURE).
REQ-006 SHALL have ports hit_0, hit_1  input  1 each  one-cycle pulse per judged lane hit.
REQ-007 SHALL have ports miss_0, miss_1  input  1 each  one-cycle pulse per enemy damage event.
REQ-008 SHALL have port disp_sel  input  1  display source: 0 = score, 1 = combo.
REQ-009 SHALL have port combo  output  7  current combo, binary.
REQ-010 SHALL have port max_combo  output  7  highest combo reached since rst.
REQ-011 SHALL have port multiplier  output  3  current multiplier, 1..4.
REQ-012 SHALL have port score  output  16  score as 4 BCD digits, thousands in [15:12].
REQ-013 SHALL have port combo_break  output  1  one-cycle pulse when a nonzero combo is lost.
REQ-014 SHALL have port display  output  7  segments, active-low.
REQ-015 SHALL have port digit  output  4  digit enables, one-hot active-low.

Function
REQ-016 SHALL ignore hit and miss pulses unless state is in 1..4 (play states).
REQ-017 SHALL clear combo, score and multiplier in the cycle after state changes from 0 to any play state; max_combo is retained.
REQ-018 SHALL derive multiplier from registered combo: 0-9 -> 1, 10-19 -> 2, 20-29 -> 3, >=30 -> 4.
REQ-019 SHALL count a qualifying cycle's hits as n = hit_0 + hit_1 (0..2) and add 10*n*multiplier points, using the multiplier before the update.
REQ-020 SHALL add points as a BCD increment of k = n*multiplier (1..8) to the tens digit, rippling carries into hundreds and thousands; the units digit stays 0.
REQ-021 SHALL saturate score at 9999 when the BCD carry leaves the thousands digit.
REQ-022 SHALL increment combo by n when neither miss is set, saturating at COMBO_MAX.
REQ-023 SHALL set combo to 0 when miss_0 or miss_1 is set, even if hits occur in the same cycle; those hits still score per REQ-019.
REQ-024 SHALL pulse combo_break for exactly one cycle, registered with the combo clear, only when the prior combo was nonzero.
REQ-025 SHALL update max_combo to the new combo whenever the new combo exceeds it.
REQ-026 SHALL register all counter and score updates on the clk edge that samples the pulse, so outputs change one cycle after the pulse.
REQ-027 SHALL free-run the refresh counter; digit index 0..3 drives digit 1110, 1101, 1011, 0111 (rightmost digit first).
REQ-028 SHALL, when disp_sel=1, show combo as 2 decimal digits in the right positions with the left two blanked (display 1111111).
REQ-029 SHALL hold the score and combo values unchanged in states 0 and 5.

Reset
REQ-030 SHALL, on rst, set combo=0, max_combo=0, multiplier=1, score=16'h0000, combo_break=0, refresh counter=0, digit=4'b1110, display=7'b1000000.
REQ-031 SHALL take rst asserted mid-game immediately, discard any in-flight pulse, and require no recovery cycles after release.

Structure
REQ-032 SHALL take the state encodings, COMBO_MAX default, points unit (10) and the 7-segment patterns for 0-9 and blank from a shared package.
REQ-033 SHALL implement the BCD-to-segment decode in one sub-module, seven_seg_decode, instantiated once on the muxed digit.
REQ-034 SHALL compute binary-to-BCD conversion for the combo display combinationally (value <= 99).

Verification
REQ-035 Bench SHALL set state 0->1 and apply 12 single hit_0 pulses: combo=12, multiplier=2, score=0x0140.
REQ-036 Bench SHALL, with combo=29, pulse hit_0 and hit_1 together: combo=31, score += 60 (multiplier 3 used), multiplier becomes 4.
REQ-037 Bench SHALL, with combo=15, pulse hit_1 and miss_0 together: combo=0, combo_break high for 1 cycle, score += 20, max_combo >= 15.
REQ-038 Bench SHALL preload score 9990 via hits, then apply a hit at multiplier 4: score=9999, with no wrap.
REQ-039 Bench SHALL pulse hits in states 0 and 5: no change to any output; then re-enter state 2: score=0, combo=0, max_combo kept.
REQ-040 Bench SHALL assert rst mid-game with hit pulses pending: all outputs match REQ-030; with SCAN_BITS=4, digit cycles 1110->1101->1011->0111 every 4 clocks.

Source files
------------

// File: rtl/combo_scorer_pkg.sv
// Shared definitions for the combo/score block: game states, scoring constants,
// 7-segment glyphs and the small arithmetic helpers used by the datapath.
package combo_scorer_pkg;

    typedef enum logic [3:0] {
        ST_GAMESTART = 4'd0,
        ST_EASY      = 4'd1,
        ST_NORMAL    = 4'd2,
        ST_HARD      = 4'd3,
        ST_INFERNO   = 4'd4,
        ST_FAILURE   = 4'd5
    } game_state_e;

    localparam int COMBO_MAX_DEF = 99;
    localparam int POINTS_UNIT   = 10;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic is_play(input logic [3:0] s);
        return (s == ST_EASY) || (s == ST_NORMAL) || (s == ST_HARD) || (s == ST_INFERNO);
    endfunction

    function automatic logic [2:0] mult_of(input logic [6:0] c);
        logic [2:0] m;
        if (c >= 7'd30)      m = 3'd4;
        else if (c >= 7'd20) m = 3'd3;
        else if (c >= 7'd10) m = 3'd2;
        else                 m = 3'd1;
        return m;
    endfunction

    // Two-digit BCD of a value up to 99; larger values give a tens code > 9
    function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Four-digit BCD add; bit 16 is the carry out of the thousands digit
    function automatic logic [16:0] bcd_add4(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [4:0]  s;
        logic        c;
        r = 17'd0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        r[16] = c;
        return r;
    endfunction

endpackage

// File: rtl/combo_scorer_seven_seg.sv
// BCD digit to active-low 7-segment glyph; any non-decimal code blanks the digit.
module seven_seg_decode
    import combo_scorer_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/combo_scorer.sv
// Combo / multiplier / BCD score tracker for the rhythm game, with a
// multiplexed 4-digit 7-segment display of either the score or the combo.
module combo_scorer
    import combo_scorer_pkg::*;
#(
    parameter int SCAN_BITS = 17,
    parameter int COMBO_MAX = COMBO_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        hit_0,
    input  logic        hit_1,
    input  logic        miss_0,
    input  logic        miss_1,
    input  logic        disp_sel,
    output logic [6:0]  combo,
    output logic [6:0]  max_combo,
    output logic [2:0]  multiplier,
    output logic [15:0] score,
    output logic        combo_break,
    output logic [6:0]  display,
    output logic [3:0]  digit
);

    localparam logic [7:0] COMBO_SAT = 8'(COMBO_MAX);

    logic [6:0]           r_combo;
    logic [6:0]           r_max;
    logic [2:0]           r_mult;
    logic [15:0]          r_score;
    logic                 r_break;
    logic [3:0]           r_prev_state;
    logic [SCAN_BITS-1:0] r_cnt;
    logic [6:0]           r_display;
    logic [3:0]           r_digit;

    logic                 w_play;
    logic                 w_start;
    logic [1:0]           w_n;
    logic [3:0]           w_k;
    logic [6:0]           w_pts;
    logic [16:0]          w_sum;
    logic [15:0]          w_score_add;
    logic [7:0]           w_combo_inc;
    logic [6:0]           w_combo_nxt;
    logic [15:0]          w_score_nxt;
    logic                 w_break_nxt;
    logic [SCAN_BITS-1:0] w_cnt_nxt;
    logic [1:0]           w_idx_nxt;
    logic [7:0]           w_combo_bcd;
    logic [3:0]           w_bcd;
    logic [6:0]           w_seg;

    assign w_play      = is_play(state);
    assign w_start     = w_play && (r_prev_state == ST_GAMESTART);
    assign w_n         = {1'b0, hit_0} + {1'b0, hit_1};
    assign w_k         = {2'b00, w_n} * {1'b0, r_mult};
    assign w_pts       = {3'b000, w_k} * 7'(POINTS_UNIT);
    assign w_sum       = bcd_add4(r_score, {8'h00, bin2bcd2(w_pts)});
    assign w_score_add = w_sum[16] ? 16'h9999 : w_sum[15:0];
    assign w_combo_inc = {1'b0, r_combo} + {6'd0, w_n};

    // Next combo / score / break; a miss wins over hits for the combo but not the score
    always_comb begin
        w_combo_nxt = r_combo;
        w_score_nxt = r_score;
        w_break_nxt = 1'b0;
        if (w_start) begin
            w_combo_nxt = 7'd0;
            w_score_nxt = 16'h0000;
        end else if (w_play) begin
            w_score_nxt = w_score_add;
            if (miss_0 || miss_1) begin
                w_combo_nxt = 7'd0;
                w_break_nxt = (r_combo != 7'd0);
            end else if (w_combo_inc > COMBO_SAT) begin
                w_combo_nxt = COMBO_SAT[6:0];
            end else begin
                w_combo_nxt = w_combo_inc[6:0];
            end
        end else begin
            w_combo_nxt = r_combo;
            w_score_nxt = r_score;
        end
    end

    // Game counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_combo      <= 7'd0;
            r_max        <= 7'd0;
            r_mult       <= 3'd1;
            r_score      <= 16'h0000;
            r_break      <= 1'b0;
            r_prev_state <= 4'd0;
        end else begin
            r_combo      <= w_combo_nxt;
            r_max        <= (w_combo_nxt > r_max) ? w_combo_nxt : r_max;
            r_mult       <= mult_of(w_combo_nxt);
            r_score      <= w_score_nxt;
            r_break      <= w_break_nxt;
            r_prev_state <= state;
        end
    end

    // Display outputs are computed for the counter's next value so digit tracks r_cnt
    assign w_cnt_nxt   = r_cnt + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    assign w_idx_nxt   = w_cnt_nxt[SCAN_BITS-1 -: 2];
    assign w_combo_bcd = bin2bcd2(r_combo);

    // Digit source mux; combo mode blanks the two left digits
    always_comb begin
        w_bcd = 4'hF;
        if (disp_sel) begin
            case (w_idx_nxt)
                2'd0:    w_bcd = w_combo_bcd[3:0];
                2'd1:    w_bcd = w_combo_bcd[7:4];
                default: w_bcd = 4'hF;
            endcase
        end else begin
            case (w_idx_nxt)
                2'd0:    w_bcd = r_score[3:0];
                2'd1:    w_bcd = r_score[7:4];
                2'd2:    w_bcd = r_score[11:8];
                2'd3:    w_bcd = r_score[15:12];
                default: w_bcd = 4'hF;
            endcase
        end
    end

    seven_seg_decode u_seg (
        .i_bcd (w_bcd),
        .o_seg (w_seg)
    );

    // Refresh scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_digit   <= 4'b1110;
            r_display <= SEG_0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_digit   <= ~(4'b0001 << w_idx_nxt);
            r_display <= w_seg;
        end
    end

    assign combo       = r_combo;
    assign max_combo   = r_max;
    assign multiplier  = r_mult;
    assign score       = r_score;
    assign combo_break = r_break;
    assign display     = r_display;
    assign digit       = r_digit;

endmodule

// File: tb/tb_combo_scorer.sv
// Directed bench for combo_scorer: scoring, combo/multiplier, saturation,
// state gating, reset and display scan, all against hand-computed values.
module tb_combo_scorer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        hit_0, hit_1, miss_0, miss_1, disp_sel;
    logic [6:0]  combo, max_combo, display;
    logic [2:0]  multiplier;
    logic [15:0] score;
    logic        combo_break;
    logic [3:0]  digit;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    combo_scorer #(.SCAN_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .hit_0       (hit_0),
        .hit_1       (hit_1),
        .miss_0      (miss_0),
        .miss_1      (miss_1),
        .disp_sel    (disp_sel),
        .combo       (combo),
        .max_combo   (max_combo),
        .multiplier  (multiplier),
        .score       (score),
        .combo_break (combo_break),
        .display     (display),
        .digit       (digit)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of pulses, driven at a negedge, then released
    task automatic step(input logic h0, input logic h1, input logic m0, input logic m1);
        hit_0 = h0; hit_1 = h1; miss_0 = m0; miss_1 = m1;
        @(negedge clk);
        hit_0 = 1'b0; hit_1 = 1'b0; miss_0 = 1'b0; miss_1 = 1'b0;
    endtask

    task automatic hits(input int count, input logic h0, input logic h1);
        for (int i = 0; i < count; i++) step(h0, h1, 1'b0, 1'b0);
    endtask

    task automatic wait_digit(input logic [3:0] t);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digit == t) break;
        end
        check_eq("digit_reached", {28'd0, digit}, {28'd0, t});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_combo"}, {25'd0, combo}, 32'd0);
        check_eq({tag, "_max"},   {25'd0, max_combo}, 32'd0);
        check_eq({tag, "_mult"},  {29'd0, multiplier}, 32'd1);
        check_eq({tag, "_score"}, {16'd0, score}, 32'h0);
        check_eq({tag, "_break"}, {31'd0, combo_break}, 32'd0);
        check_eq({tag, "_digit"}, {28'd0, digit}, 32'hE);
        check_eq({tag, "_disp"},  {25'd0, display}, 32'h40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_dig;
        rst = 1'b1; state = 4'd0; disp_sel = 1'b0;
        hit_0 = 1'b0; hit_1 = 1'b0; miss_0 = 1'b0; miss_1 = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

        // Start game, 12 single hits
        state = 4'd1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        hits(12, 1'b1, 1'b0);
        check_eq("c12_combo", {25'd0, combo}, 32'd12);
        check_eq("c12_mult",  {29'd0, multiplier}, 32'd2);
        check_eq("c12_score", {16'd0, score}, 32'h0140);
        check_eq("c12_max",   {25'd0, max_combo}, 32'd12);

        // Combo display: 12 -> right digits '2','1', left two blank
        disp_sel = 1'b1;
        wait_digit(4'b1110); check_eq("cdisp_units", {25'd0, display}, 32'h24);
        wait_digit(4'b1101); check_eq("cdisp_tens",  {25'd0, display}, 32'h79);
        wait_digit(4'b1011); check_eq("cdisp_blank2", {25'd0, display}, 32'h7F);
        wait_digit(4'b0111); check_eq("cdisp_blank3", {25'd0, display}, 32'h7F);
        // Score display 0140
        disp_sel = 1'b0;
        wait_digit(4'b1110); check_eq("sdisp_0", {25'd0, display}, 32'h40);
        wait_digit(4'b1101); check_eq("sdisp_4", {25'd0, display}, 32'h19);
        wait_digit(4'b1011); check_eq("sdisp_1", {25'd0, display}, 32'h79);

        // Climb to 29, then a double hit at multiplier 3
        hits(17, 1'b1, 1'b0);
        check_eq("c29_combo", {25'd0, combo}, 32'd29);
        check_eq("c29_score", {16'd0, score}, 32'h0570);
        check_eq("c29_mult",  {29'd0, multiplier}, 32'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("c31_combo", {25'd0, combo}, 32'd31);
        check_eq("c31_score", {16'd0, score}, 32'h0630);
        check_eq("c31_mult",  {29'd0, multiplier}, 32'd4);
        check_eq("c31_max",   {25'd0, max_combo}, 32'd31);

        // Plain miss breaks a nonzero combo
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("miss_combo", {25'd0, combo}, 32'd0);
        check_eq("miss_break", {31'd0, combo_break}, 32'd1);
        check_eq("miss_score", {16'd0, score}, 32'h0630);
        check_eq("miss_mult",  {29'd0, multiplier}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("miss_break_end", {31'd0, combo_break}, 32'd0);

        // combo 15, then hit_1 with miss_0 in the same cycle
        hits(15, 1'b1, 1'b0);
        check_eq("c15_combo", {25'd0, combo}, 32'd15);
        check_eq("c15_score", {16'd0, score}, 32'h0830);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("hm_combo", {25'd0, combo}, 32'd0);
        check_eq("hm_break", {31'd0, combo_break}, 32'd1);
        check_eq("hm_score", {16'd0, score}, 32'h0850);
        check_eq("hm_max",   {25'd0, max_combo}, 32'd31);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("hm_break_end", {31'd0, combo_break}, 32'd0);

        // Non-play states hold everything
        hits(3, 1'b1, 1'b0);
        check_eq("pre_hold_score", {16'd0, score}, 32'h0880);
        state = 4'd5;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("fail_combo", {25'd0, combo}, 32'd3);
        check_eq("fail_score", {16'd0, score}, 32'h0880);
        check_eq("fail_break", {31'd0, combo_break}, 32'd0);
        state = 4'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("gs_combo", {25'd0, combo}, 32'd3);
        check_eq("gs_score", {16'd0, score}, 32'h0880);
        check_eq("gs_mult",  {29'd0, multiplier}, 32'd1);
        state = 4'd2;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("re_combo", {25'd0, combo}, 32'd0);
        check_eq("re_score", {16'd0, score}, 32'h0);
        check_eq("re_max",   {25'd0, max_combo}, 32'd31);

        // Build score to 9990 ending at multiplier 4, then saturate
        hits(3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        hits(15, 1'b1, 1'b1);
        check_eq("sat_pre_score", {16'd0, score}, 32'h0630);
        check_eq("sat_pre_combo", {25'd0, combo}, 32'd30);
        hits(117, 1'b1, 1'b1);
        check_eq("s9990_score", {16'd0, score}, 32'h9990);
        check_eq("s9990_combo", {25'd0, combo}, 32'd99);
        check_eq("s9990_mult",  {29'd0, multiplier}, 32'd4);
        check_eq("s9990_max",   {25'd0, max_combo}, 32'd99);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("s9999_score", {16'd0, score}, 32'h9999);
        check_eq("s9999_combo", {25'd0, combo}, 32'd99);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("s9999_hold", {16'd0, score}, 32'h9999);

        // Reset mid-game with hits in flight
        hit_0 = 1'b1; hit_1 = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        hit_0 = 1'b0; hit_1 = 1'b0;
        check_reset_state("midrst");
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            exp_dig = ~(4'b0001 << ((j / 4) % 4));
            check_eq("scan_digit", {28'd0, digit}, {28'd0, exp_dig});
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
